// File: rtl/fwd_select_ctrl_if.sv
// ID-stage instruction fields into the forwarding controller, and the EX select and stall outputs back.
interface fwd_select_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic [SEL_W-1:0]  ex_fwd_a_sel;
  logic [SEL_W-1:0]  ex_fwd_b_sel;
  logic              load_use_stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input  ex_fwd_a_sel, ex_fwd_b_sel, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output ex_fwd_a_sel, ex_fwd_b_sel, load_use_stall
  );
endinterface

// File: rtl/fwd_select_ctrl.sv
// EX-stage operand forwarding select generator and load-use stall detector.
// Tracks the destination registers of the EX and MEM stage occupants.
module fwd_select_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
) (
  input logic              clk,
  input logic              rst_n,
  fwd_select_ctrl_if.slave bus
);

  typedef enum logic [SEL_W-1:0] {
    SEL_RF  = SEL_W'(0),
    SEL_MEM = SEL_W'(1),
    SEL_WB  = SEL_W'(2)
  } sel_e;

  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_ld_q, ex_ld_d;

  // WB needs no record: the register file is write-first, so that distance never forwards.
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_rw_q;

  sel_e sel_a_q, sel_a_d;
  sel_e sel_b_q, sel_b_d;
  logic stall;

  function automatic sel_e next_sel(input logic [REG_AW-1:0] rs,
                                    input logic ex_v, input logic [REG_AW-1:0] ex_rd,
                                    input logic ex_rw, input logic ex_ld,
                                    input logic mem_v, input logic [REG_AW-1:0] mem_rd,
                                    input logic mem_rw);
    sel_e s;
    s = SEL_RF;
    if (ex_v && ex_rw && (ex_rd == rs) && (rs != '0) && !ex_ld)
      s = SEL_MEM;
    else if (mem_v && mem_rw && (mem_rd == rs) && (rs != '0))
      s = SEL_WB;
    return s;
  endfunction

  always_comb begin
    stall = rst_n && bus.id_valid && ex_valid_q && ex_ld_q && ex_rw_q && (ex_rd_q != '0) &&
            ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2));
  end

  always_comb begin
    ex_valid_d = 1'b0;
    ex_rd_d    = '0;
    ex_rw_d    = 1'b0;
    ex_ld_d    = 1'b0;
    sel_a_d    = SEL_RF;
    sel_b_d    = SEL_RF;
    if (!bus.flush && !stall) begin
      ex_valid_d = bus.id_valid;
      ex_rd_d    = bus.id_rd;
      ex_rw_d    = bus.id_reg_write;
      ex_ld_d    = bus.id_mem_read;
      sel_a_d    = next_sel(bus.id_rs1, ex_valid_q, ex_rd_q, ex_rw_q, ex_ld_q,
                            mem_valid_q, mem_rd_q, mem_rw_q);
      sel_b_d    = next_sel(bus.id_rs2, ex_valid_q, ex_rd_q, ex_rw_q, ex_ld_q,
                            mem_valid_q, mem_rd_q, mem_rw_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_ld_q     <= ex_ld_d;
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_rw_q    <= ex_rw_q;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
    end
  end

  assign bus.ex_fwd_a_sel   = sel_a_q;
  assign bus.ex_fwd_b_sel   = sel_b_q;
  assign bus.load_use_stall = stall;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed and randomized checks of fwd_select_ctrl against an instruction-history model.
module tb_fwd_select_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  fwd_select_ctrl_if #(.REG_AW(5), .SEL_W(2)) bus ();

  fwd_select_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One issued instruction as seen by a later consumer.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } instr_t;

  // hist[0] is the instruction now in EX, hist[1] the one in MEM.
  instr_t     hist [2];
  logic [1:0] exp_a, exp_b;
  logic       sel_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic produces(input instr_t p, input logic [4:0] r);
    return p.valid && p.rw && (p.rd == r) && (r != 5'd0);
  endfunction

  // Distance 1 forwards the ALU result from MEM (not for loads); distance 2 forwards from WB.
  function automatic logic [1:0] expected_sel(input logic [4:0] r);
    if (produces(hist[0], r) && !hist[0].ld) return 2'b01;
    if (produces(hist[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input logic rn, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic rw, input logic ld, input logic fl);
    logic   stall_m;
    instr_t issued;
    if (sel_known) begin
      check_eq("sel_a", 32'(bus.ex_fwd_a_sel), 32'(exp_a));
      check_eq("sel_b", 32'(bus.ex_fwd_b_sel), 32'(exp_b));
    end
    rst_n            = rn;
    bus.id_valid     = v;
    bus.id_rs1       = s1;
    bus.id_rs2       = s2;
    bus.id_rd        = d;
    bus.id_reg_write = rw;
    bus.id_mem_read  = ld;
    bus.flush        = fl;
    #1;
    stall_m = rn && v && produces(hist[0], s1 == hist[0].rd ? s1 : s2) && hist[0].ld &&
              ((hist[0].rd == s1) || (hist[0].rd == s2));
    check_eq("stall", 32'(bus.load_use_stall), 32'(stall_m));
    if (!rn) begin
      hist[0] = '0;
      hist[1] = '0;
      exp_a   = 2'b00;
      exp_b   = 2'b00;
    end else begin
      if (fl || stall_m) begin
        issued = '0;
        exp_a  = 2'b00;
        exp_b  = 2'b00;
      end else begin
        issued = '{valid: v, rd: d, rw: rw, ld: ld};
        exp_a  = expected_sel(s1);
        exp_b  = expected_sel(s2);
      end
      hist[1] = hist[0];
      hist[0] = issued;
    end
    sel_known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic r_rn, r_v, r_rw, r_ld, r_fl;
    logic [4:0] r_s1, r_s2, r_d;
    hist[0] = '0;
    hist[1] = '0;
    exp_a = 2'b00;
    exp_b = 2'b00;
    rst_n = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.flush = 1'b0;
    @(negedge clk);

    // Reset held two cycles with ID toggling, then a reader right after release.
    step(0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0);
    step(0, 1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    step(1, 1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // add x5,x1,x2 ; sub x6,x5,x3
    step(1, 1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    step(1, 1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    // add x5 ; nop ; or x7,x4,x5
    step(1, 1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 1, 5'd4, 5'd5, 5'd7, 1, 0, 0);
    // add x5 ; addi x5 ; and x8,x5,x5
    step(1, 1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    step(1, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0);
    step(1, 1, 5'd5, 5'd5, 5'd8, 1, 0, 0);
    // lw x9,0(x1) ; add x10,x9,x9 (held one cycle)
    step(1, 1, 5'd1, 5'd0, 5'd9, 1, 1, 0);
    step(1, 1, 5'd9, 5'd9, 5'd10, 1, 0, 0);
    step(1, 1, 5'd9, 5'd9, 5'd10, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    // add x0,x1,x2 ; add x3,x0,x0
    step(1, 1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
    step(1, 1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    // sw x5 ; reader of x5
    step(1, 1, 5'd1, 5'd5, 5'd5, 0, 0, 0);
    step(1, 1, 5'd5, 5'd5, 5'd11, 1, 0, 0);
    // lw x9 ; consumer flushed in the stall cycle ; next instruction unaffected
    step(1, 1, 5'd1, 5'd0, 5'd9, 1, 1, 0);
    step(1, 1, 5'd9, 5'd2, 5'd12, 1, 0, 1);
    step(1, 1, 5'd3, 5'd4, 5'd13, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Small register range keeps hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      r_rn = ($urandom_range(0, 99) >= 3);
      r_v  = ($urandom_range(0, 99) < 85);
      r_s1 = 5'($urandom_range(0, 3));
      r_s2 = 5'($urandom_range(0, 3));
      r_d  = 5'($urandom_range(0, 3));
      r_rw = ($urandom_range(0, 99) < 70);
      r_ld = ($urandom_range(0, 99) < 30);
      r_fl = ($urandom_range(0, 99) < 10);
      step(r_rn, r_v, r_s1, r_s2, r_d, r_rw, r_ld, r_fl);
    end
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
